// File: rtl/pc_unit.sv
// pc_unit: RV32 program counter with boot/run/halt control and trap steering.
// Drives the instruction-memory fetch address and a fetch-valid qualifier.
//
// Parameters:
//   N            PC width in bits
//   RESET_VECTOR PC value loaded on reset
//   TRAP_VECTOR  PC value loaded on a trap or a misaligned redirect
//   CNT_W        width of the sequential-fetch counter
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous, active-low reset
//   instr_compressed_i  current fetch is a 16-bit instruction (PC_COMPRESSED_EN only)
//   stall_i             hold the PC this cycle
//   redirect_valid_i    branch/jump taken
//   redirect_target_i   branch/jump target address
//   trap_i              exception/interrupt request
//   halt_i              request to enter HALT
//   resume_i            leave HALT
//   pc_o                current fetch address
//   pc_plus_o           pc_o + increment (combinational, wraps mod 2^N)
//   fetch_valid_o       pc_o is a valid fetch this cycle
//   misalign_o          one-cycle pulse after a misaligned redirect
//   fetch_count_o       saturating count of sequential PC advances
//
// Optional feature macro: PC_COMPRESSED_EN
//   defined   -> adds instr_compressed_i; increment is 2 or 4,
//                targets only need target[0] == 0
//   undefined -> increment is always 4, targets need target[1:0] == 0

module pc_unit #(
    parameter int          N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(32'h0000_0000),
    parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0000_0100),
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef PC_COMPRESSED_EN
    input  logic             instr_compressed_i,
`endif
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [N-1:0]     redirect_target_i,
    input  logic             trap_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [N-1:0]     pc_o,
    output logic [N-1:0]     pc_plus_o,
    output logic             fetch_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] pc_inc;
    logic         target_aligned;

    // One-hot RUN-state selects, already resolved in priority order.
    logic sel_trap;
    logic sel_redir;
    logic sel_misalign;
    logic sel_stall;
    logic sel_halt;

`ifdef PC_COMPRESSED_EN
    assign pc_inc         = instr_compressed_i ? N'(2) : N'(4);
    assign target_aligned = ~redirect_target_i[0];
`else
    assign pc_inc         = N'(4);
    assign target_aligned = (redirect_target_i[1:0] == 2'b00);
`endif

    assign pc_plus_o = pc_o + pc_inc;

    assign sel_trap     = trap_i;
    assign sel_redir    = ~trap_i & redirect_valid_i & target_aligned;
    assign sel_misalign = ~trap_i & redirect_valid_i & ~target_aligned;
    assign sel_stall    = ~trap_i & ~redirect_valid_i & stall_i;
    assign sel_halt     = ~trap_i & ~redirect_valid_i & ~stall_i & halt_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BOOT;
            pc_o          <= RESET_VECTOR;
            fetch_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            // Pulse output: only the misaligned-redirect branch raises it.
            misalign_o <= 1'b0;

            unique case (state)
                BOOT: begin
                    // First fetch is at RESET_VECTOR, so the PC is untouched.
                    state         <= RUN;
                    fetch_valid_o <= 1'b1;
                end

                RUN: begin
                    fetch_valid_o <= 1'b1;
                    unique case (1'b1)
                        sel_trap: begin
                            pc_o <= TRAP_VECTOR;
                        end
                        sel_redir: begin
                            pc_o <= redirect_target_i;
                        end
                        sel_misalign: begin
                            pc_o       <= TRAP_VECTOR;
                            misalign_o <= 1'b1;
                        end
                        sel_stall: begin
                            pc_o <= pc_o;
                        end
                        sel_halt: begin
                            state         <= HALT;
                            fetch_valid_o <= 1'b0;
                        end
                        default: begin
                            pc_o <= pc_plus_o;
                            // Saturate rather than wrap.
                            if (fetch_count_o != {CNT_W{1'b1}}) begin
                                fetch_count_o <= fetch_count_o + CNT_W'(1);
                            end
                        end
                    endcase
                end

                HALT: begin
                    fetch_valid_o <= 1'b0;
                    if (trap_i) begin
                        pc_o          <= TRAP_VECTOR;
                        state         <= RUN;
                        fetch_valid_o <= 1'b1;
                    end else if (resume_i) begin
                        state         <= RUN;
                        fetch_valid_o <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover through BOOT.
                    state         <= BOOT;
                    fetch_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (default build).
// Stimulus pushes expected post-edge outputs; a monitor pops and compares.

module tb_pc_unit;

    localparam int CW = 4;

    typedef struct {
        logic [31:0]   pc;
        logic          fv;
        logic          mis;
        logic [CW-1:0] cnt;
        string         nm;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          stall_i;
    logic          redirect_valid_i;
    logic [31:0]   redirect_target_i;
    logic          trap_i;
    logic          halt_i;
    logic          resume_i;
    logic [31:0]   pc_o;
    logic [31:0]   pc_plus_o;
    logic          fetch_valid_o;
    logic          misalign_o;
    logic [CW-1:0] fetch_count_o;
`ifdef PC_COMPRESSED_EN
    logic          instr_compressed_i;
    initial instr_compressed_i = 1'b0;
`endif

    exp_t sb_q[$];
    exp_t e;
    event sb_ev;
    int   n_vec;
    int   n_err;

    pc_unit #(
        .N(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef PC_COMPRESSED_EN
        .instr_compressed_i(instr_compressed_i),
`endif
        .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .trap_i(trap_i),
        .halt_i(halt_i),
        .resume_i(resume_i),
        .pc_o(pc_o),
        .pc_plus_o(pc_plus_o),
        .fetch_valid_o(fetch_valid_o),
        .misalign_o(misalign_o),
        .fetch_count_o(fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, want finish before 100000");
        $fatal(1);
    end

    // Monitor: one expected record per sample point.
    always @(negedge clk or sb_ev) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (pc_o !== e.pc || pc_plus_o !== e.pc + 32'd4 ||
                fetch_valid_o !== e.fv || misalign_o !== e.mis ||
                fetch_count_o !== e.cnt) begin
                n_err++;
                $display("FAIL %s: got pc=%h plus=%h fv=%b mis=%b cnt=%0d want pc=%h plus=%h fv=%b mis=%b cnt=%0d",
                         e.nm, pc_o, pc_plus_o, fetch_valid_o, misalign_o,
                         fetch_count_o, e.pc, e.pc + 32'd4, e.fv, e.mis, e.cnt);
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic fv,
                        input logic ms, input int cnt, input string nm);
        exp_t x;
        x.pc  = pc;
        x.fv  = fv;
        x.mis = ms;
        x.cnt = CW'(cnt);
        x.nm  = nm;
        sb_q.push_back(x);
    endtask

    task automatic step(input logic st, input logic rv,
                        input logic [31:0] tg, input logic tr,
                        input logic hl, input logic rs,
                        input logic [31:0] pc, input logic fv,
                        input logic ms, input int cnt, input string nm);
        stall_i           = st;
        redirect_valid_i  = rv;
        redirect_target_i = tg;
        trap_i            = tr;
        halt_i            = hl;
        resume_i          = rs;
        @(posedge clk);
        push(pc, fv, ms, cnt, nm);
        #1;
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        reset_n           = 1'b0;
        stall_i           = 1'b0;
        redirect_valid_i  = 1'b0;
        redirect_target_i = '0;
        trap_i            = 1'b0;
        halt_i            = 1'b0;
        resume_i          = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 0, "reset");
        #11 reset_n = 1'b1;

        // Boot then sequential fetch.
        step(0, 0, 0, 0, 0, 0, 32'h00, 1, 0, 0, "boot_run0");
        step(0, 0, 0, 0, 0, 0, 32'h04, 1, 0, 1, "seq4");
        step(0, 0, 0, 0, 0, 0, 32'h08, 1, 0, 2, "seq8");
        step(0, 0, 0, 0, 0, 0, 32'h0C, 1, 0, 3, "seqC");
        step(0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 4, "seq10");

        // Stall, then stall with redirect.
        step(1, 0, 0, 0, 0, 0, 32'h10, 1, 0, 4, "stall1");
        step(1, 0, 0, 0, 0, 0, 32'h10, 1, 0, 4, "stall2");
        step(1, 1, 32'h200, 0, 0, 0, 32'h200, 1, 0, 4, "stall_redir");

        // Misaligned redirect, pulse lasts one cycle.
        step(0, 1, 32'h202, 0, 0, 0, 32'h100, 1, 1, 4, "misalign");
        step(0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 5, "mis_clear");

        // Trap beats redirect.
        step(0, 1, 32'h300, 1, 0, 0, 32'h100, 1, 0, 5, "trap_prio");
        step(0, 1, 32'h03C, 0, 0, 0, 32'h03C, 1, 0, 5, "redir3C");
        step(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 6, "seq40");

        // Halt, hold with redirect ignored, resume.
        step(0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 6, "halt");
        for (int k = 0; k < 5; k++) begin
            step(k[0], 1, 32'h500, 0, 1, 0, 32'h40, 0, 0, 6, "halt_hold");
        end
        step(0, 0, 0, 0, 0, 1, 32'h40, 1, 0, 6, "resume");
        step(0, 0, 0, 0, 0, 0, 32'h44, 1, 0, 7, "seq44");

        // Trap leaves HALT; stall beats halt.
        step(0, 0, 0, 0, 1, 0, 32'h44, 0, 0, 7, "halt2");
        step(0, 0, 0, 1, 0, 0, 32'h100, 1, 0, 7, "halt_trap");
        step(0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 8, "seq104");
        step(1, 0, 0, 0, 1, 0, 32'h104, 1, 0, 8, "stall_halt");

        // Wrap-around.
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 8, "redir_top");
        step(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 9, "wrap");

        // Asynchronous reset between edges.
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 push(32'h0, 1'b0, 1'b0, 0, "async_reset");
        ->sb_ev;
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // BOOT ignores inputs; then count up to saturation.
        step(0, 1, 32'h80, 1, 0, 0, 32'h0, 1, 0, 0, "boot_ignore");
        for (int k = 1; k <= 17; k++) begin
            step(0, 0, 0, 0, 0, 0, 32'(4 * k), 1, 0,
                 (k > 15) ? 15 : k, "sat");
        end

        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
